// File: rtl/adc_spi_reader.sv
// SPI master that reads a 12-bit ADC in 16-SCLK frames (4 leading zeros, then D11..D0).
// Defining ADC_LEADZERO_CHECK_EN enables the leading-zero frame check on frame_err.
module adc_spi_reader #(
  parameter int CLK_DIV      = 2,
  parameter int QUIET_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        miso,
  output logic        cs_n,
  output logic        sclk,
  output logic [11:0] adc,
  output logic        sample_valid,
  output logic        busy,
  output logic        frame_err
);

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);
  localparam logic [4:0] NUM_BITS   = 5'd16;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, QUIET} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bits_q, bits_d;
  logic [15:0] shreg_q, shreg_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        valid_q, valid_d;
  logic [11:0] adc_q, adc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bits_q  <= 5'd0;
      shreg_q <= 16'd0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      valid_q <= 1'b0;
      adc_q   <= 12'h000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      shreg_q <= shreg_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      valid_q <= valid_d;
      adc_q   <= adc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    shreg_d = shreg_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    adc_d   = adc_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        cnt_d  = 8'd0;
        bits_d = 5'd0;
        if (enable) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SHIFT;
          sclk_d  = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SHIFT: begin
        // Each half-period ends with either a rising edge (capture) or a falling edge.
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[14:0], miso};
            bits_d  = bits_q + 5'd1;
          end else if (bits_q == NUM_BITS) begin
            state_d = DONE;
            cs_n_d  = 1'b1;
            adc_d   = shreg_q[11:0];
            valid_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = QUIET;
        cnt_d   = 8'd0;
      end
      QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          cnt_d  = 8'd0;
          bits_d = 5'd0;
          if (enable) begin
            state_d = SETUP;
            cs_n_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ADC_LEADZERO_CHECK_EN
  logic ferr_q, ferr_d;

  // Loaded together with adc, so the flag always describes the sample on adc.
  always_comb begin
    ferr_d = ferr_q;
    if (valid_d) ferr_d = |shreg_q[15:12];
  end

  always_ff @(posedge clk) begin
    if (rst) ferr_q <= 1'b0;
    else     ferr_q <= ferr_d;
  end

  assign frame_err = ferr_q;
`else
  logic unused_lead;
  assign unused_lead = ^shreg_q[15:12];
  assign frame_err   = 1'b0;
`endif

  assign cs_n         = cs_n_q;
  assign sclk         = sclk_q;
  assign adc          = adc_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/adc_spi_reader.md
ADC_SPI_READER -- requirements
Module: adc_spi_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCLK half-period in clk cycles, legal 1..255.
REQ-002 SHALL have parameter QUIET_CYCLES, default 8: minimum cs_n-high time between frames in clk cycles, legal 1..255.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  high = continuous back-to-back conversions.
REQ-006 SHALL have port miso  input  1  serial data from the 12-bit ADC, MSB first.
REQ-007 SHALL have port cs_n  output  1  ADC chip select, active-low, registered.
REQ-008 SHALL have port sclk  output  1  ADC serial clock, idles high, registered.
REQ-009 SHALL have port adc  output  12  last completed sample, held between frames; feeds the mean-current logic ADC input.
REQ-010 SHALL have port sample_valid  output  1  one-clk pulse when adc updates.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port frame_err  output  1  leading-zero check result (see Configuration).

Function
REQ-013 SHALL implement states IDLE, SETUP, SHIFT, DONE, QUIET.
REQ-014 IDLE: cs_n=1, sclk=1; enable sampled high -> SETUP with cs_n=0 on the next clk edge.
REQ-015 SETUP: hold cs_n=0, sclk=1 for CLK_DIV cycles, then -> SHIFT.
REQ-016 SHIFT: 16 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high; sclk begins with a falling edge.
REQ-017 SHALL sample miso into a 16-bit shift register in the clk cycle where sclk goes 0->1; bit 15 first.
REQ-018 Frame format: 4 leading zeros then D11..D0; adc gets shift register bits 11:0.
REQ-019 After the 16th rising sclk edge -> DONE: cs_n=1, adc updated, sample_valid=1 for exactly that one cycle.
REQ-020 DONE -> QUIET; QUIET holds cs_n=1 for QUIET_CYCLES cycles, then IDLE if enable=0, else SETUP directly.
REQ-021 Frame length at defaults: 1 cs_n-low edge to cs_n rise = CLK_DIV + 32*CLK_DIV = 66 clk cycles; frame period with enable held = 66+1+8 = 75 cycles.
REQ-022 enable deasserted mid-frame SHALL NOT abort; the frame completes, then IDLE after QUIET.
REQ-023 Half-period counter SHALL be 8 bits, bit counter 5 bits; no wrap beyond 16 bits per frame.
REQ-024 adc SHALL change only in DONE; sample_valid SHALL never assert twice within QUIET_CYCLES+1 cycles.

Reset
REQ-025 rst high SHALL force IDLE on the next edge regardless of state, including mid-SHIFT.
REQ-026 Reset values: cs_n=1, sclk=1, adc=12'h000, sample_valid=0, busy=0, frame_err=0, counters and shift register 0.
REQ-027 A frame interrupted by rst SHALL NOT produce sample_valid and SHALL NOT modify adc.

Configuration
REQ-028 Macro ADC_LEADZERO_CHECK_EN SHALL gate the leading-zero check.
REQ-029 Defined: in DONE, frame_err SHALL load 1 if shift register bits 15:12 != 0, else 0; adc still updates; frame_err holds until next DONE or rst.
REQ-030 Undefined: frame_err SHALL be tied 0 and bits 15:12 ignored.

Verification
REQ-031 Defaults, ADC model drives 16'h0A5C, enable pulsed one cycle -> cs_n low 66 cycles, exactly 16 sclk rising edges, adc=12'hA5C, one sample_valid pulse, busy low 9 cycles after cs_n rise.
REQ-032 enable held, model drives 12'h001 then 12'hFFF -> sample_valid pulses 75 cycles apart, adc=12'h001 then 12'hFFF, cs_n high >=8 cycles between frames.
REQ-033 rst asserted at 8th sclk rising edge while converting 12'h7FF -> next edge cs_n=1, sclk=1, adc=12'h000, no sample_valid; new frame starts only after rst low and enable high.
REQ-034 enable dropped at 3rd sclk edge, model 12'h800 -> frame completes, adc=12'h800, then IDLE, no further cs_n activity.
REQ-035 ADC_LEADZERO_CHECK_EN defined, model drives 16'h1123 -> adc=12'h123, frame_err=1; next frame 16'h0123 -> frame_err=0; macro undefined -> frame_err stays 0.
REQ-036 CLK_DIV=1, QUIET_CYCLES=1 -> sclk period 2 clk cycles, frame period 35 cycles, data still captured correctly for 12'h555 and 12'hAAA.
